// File: rtl/cfg_spi_pkg.sv
// cfg_spi_pkg: frame geometry, opcode encodings and FSM state type for cfg_spi_ctrl
package cfg_spi_pkg;
  localparam int FRAME_LEN = 20;
  localparam int HDR_LEN = 4;
  localparam int RD_LEN = 8;
  localparam logic OP_WR = 1'b1;
  localparam logic OP_RD = 1'b0;
  typedef enum logic [2:0] {IDLE, HDR, DATA, COMMIT, WAIT_CS} state_e;
endpackage

// File: rtl/cfg_spi_sync.sv
// cfg_spi_sync: STAGES-deep synchronizer with one edge-detect flop
// Ports: clk_i system clock; d_i async input; lvl_o synchronized level;
//        rise_o/fall_o single-cycle edge pulses on the synchronized level.
// The flops are deliberately not reset: after a mid-frame reset the chain keeps
// tracking the pads, so no false cs_n fall is produced and a fresh fall is needed.
module cfg_spi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
    prev_d = sync_q[STAGES-1];
  end
  always_ff @(posedge clk_i) begin
    sync_q <= sync_d;
    prev_q <= prev_d;
  end
  assign lvl_o  = sync_q[STAGES-1];
  assign rise_o = lvl_o & ~prev_q;
  assign fall_o = ~lvl_o & prev_q;
endmodule

// File: rtl/cfg_spi_ctrl.sv
// cfg_spi_ctrl: oversampled mode-0 SPI slave that writes and reads back the config register block
// Ports: clk_i/rst_n_i (sync, active-low); spi_sclk_i/spi_cs_n_i/spi_mosi_i async pads;
//        spi_miso_o readback data; reg_wr_o/reg_adr_o/reg_dat_o register write port;
//        mux_adr_o/mux_dat_i readback mux; busy_o frame in progress; frame_err_o bad/aborted frame.
// Build option: define CFG_SPI_READBACK_EN to include the read path (mux select, capture, MISO).
module cfg_spi_ctrl
  import cfg_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        spi_sclk_i,
  input  logic        spi_cs_n_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o,
  output logic        reg_wr_o,
  output logic [1:0]  reg_adr_o,
  output logic [15:0] reg_dat_o,
  output logic [2:0]  mux_adr_o,
  input  logic [7:0]  mux_dat_i,
  output logic        busy_o,
  output logic        frame_err_o
);
  logic sclk_rise, sclk_fall, unused_sclk_lvl;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi, unused_mosi_rise, unused_mosi_fall;
  cfg_spi_sync #(.STAGES(SYNC_STAGES)) u_sclk (
    .clk_i(clk_i), .d_i(spi_sclk_i), .lvl_o(unused_sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  cfg_spi_sync #(.STAGES(SYNC_STAGES)) u_cs (
    .clk_i(clk_i), .d_i(spi_cs_n_i), .lvl_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );
  cfg_spi_sync #(.STAGES(SYNC_STAGES)) u_mosi (
    .clk_i(clk_i), .d_i(spi_mosi_i), .lvl_o(mosi), .rise_o(unused_mosi_rise), .fall_o(unused_mosi_fall)
  );
  state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [FRAME_LEN-2:0] sr_q, sr_d;
  logic [FRAME_LEN-1:0] frame;
  logic [1:0] reg_adr_q, reg_adr_d;
  logic [15:0] reg_dat_q, reg_dat_d;
  logic reg_wr_q, reg_wr_d, err_q, err_d, busy_q, busy_d;
  logic in_frame, last, rd_hit;
  assign in_frame = state_q == HDR || state_q == DATA;
  // the 20th bit is taken combinationally from mosi so the strobe lands one cycle after its edge
  assign frame = {sr_q, mosi};
  assign last = state_q == DATA && sclk_rise && cnt_q == 5'(FRAME_LEN - 1);
  assign rd_hit = state_q == HDR && sclk_rise && cnt_q == 5'(HDR_LEN - 1) && sr_q[2] == OP_RD && !cs_rise;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sr_d = sr_q;
    reg_adr_d = reg_adr_q;
    reg_dat_d = reg_dat_q;
    reg_wr_d = 1'b0;
    err_d = 1'b0;
    if (state_q == IDLE && cs_fall) begin
      state_d = HDR;
      cnt_d = '0;
    end
    if (in_frame && sclk_rise) begin
      cnt_d = cnt_q + 5'd1;
      sr_d = {sr_q[FRAME_LEN-3:0], mosi};
    end
    if (state_q == HDR && sclk_rise && cnt_q == 5'(HDR_LEN - 1)) state_d = DATA;
    // a final edge coincident with cs_n rise still completes the frame
    if (last) begin
      state_d = COMMIT;
      if (frame[19] == OP_WR) begin
        err_d = frame[18];
        reg_wr_d = !frame[18];
        reg_adr_d = frame[18] ? reg_adr_q : frame[17:16];
        reg_dat_d = frame[18] ? reg_dat_q : frame[15:0];
      end
    end else if (in_frame && cs_rise) begin
      state_d = IDLE;
      err_d = 1'b1;
    end
    // level rather than edge so a cs_n rise seen during COMMIT is not missed
    if (state_q == COMMIT || state_q == WAIT_CS) state_d = cs_lvl ? IDLE : WAIT_CS;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sr_q <= '0;
      reg_adr_q <= '0;
      reg_dat_q <= '0;
      reg_wr_q <= 1'b0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sr_q <= sr_d;
      reg_adr_q <= reg_adr_d;
      reg_dat_q <= reg_dat_d;
      reg_wr_q <= reg_wr_d;
      err_q <= err_d;
      busy_q <= busy_d;
    end
  end
  assign reg_wr_o = reg_wr_q;
  assign reg_adr_o = reg_adr_q;
  assign reg_dat_o = reg_dat_q;
  assign frame_err_o = err_q;
  assign busy_o = busy_q;
`ifdef CFG_SPI_READBACK_EN
  logic [2:0] mux_adr_q, mux_adr_d;
  logic [RD_LEN-1:0] rd_sr_q, rd_sr_d;
  logic cap_q, cap_d, miso_q, miso_d;
  always_comb begin
    mux_adr_d = rd_hit ? {sr_q[1:0], mosi} : mux_adr_q;
    cap_d = rd_hit;
    rd_sr_d = cap_q ? mux_dat_i : sclk_fall ? {rd_sr_q[RD_LEN-2:0], 1'b0} : rd_sr_q;
    if (state_q == IDLE && cs_fall) rd_sr_d = '0;
    miso_d = cs_lvl ? 1'b0 : sclk_fall ? rd_sr_q[RD_LEN-1] : miso_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      mux_adr_q <= '0;
      rd_sr_q <= '0;
      cap_q <= 1'b0;
      miso_q <= 1'b0;
    end else begin
      mux_adr_q <= mux_adr_d;
      rd_sr_q <= rd_sr_d;
      cap_q <= cap_d;
      miso_q <= miso_d;
    end
  end
  assign mux_adr_o = mux_adr_q;
  assign spi_miso_o = miso_q;
`else
  logic unused_rd;
  assign unused_rd = ^{mux_dat_i, sclk_fall, rd_hit};
  assign mux_adr_o = '0;
  assign spi_miso_o = 1'b0;
`endif
endmodule

// File: tb/tb_cfg_spi_ctrl.sv
// tb_cfg_spi_ctrl: scoreboard bench for cfg_spi_ctrl driving SPI frames from the pads
module tb_cfg_spi_ctrl;
  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  logic spi_sclk_i = 1'b0;
  logic spi_cs_n_i = 1'b1;
  logic spi_mosi_i = 1'b0;
  logic spi_miso_o, reg_wr_o, busy_o, frame_err_o;
  logic [1:0] reg_adr_o;
  logic [15:0] reg_dat_o;
  logic [2:0] mux_adr_o;
  logic [7:0] mux_dat_i;
  int n_checks = 0;
  int n_errors = 0;
  int n_wr = 0;
  int n_err = 0;
  logic [17:0] wr_q[$];
  logic miso_q[$];
`ifdef CFG_SPI_READBACK_EN
  localparam logic [2:0] EXP_MUX = 3'd5;
  localparam logic [7:0] EXP_RD = 8'h96;
`else
  localparam logic [2:0] EXP_MUX = 3'd0;
  localparam logic [7:0] EXP_RD = 8'h00;
`endif
  cfg_spi_ctrl #(.SYNC_STAGES(2)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .spi_sclk_i(spi_sclk_i), .spi_cs_n_i(spi_cs_n_i),
    .spi_mosi_i(spi_mosi_i), .spi_miso_o(spi_miso_o), .reg_wr_o(reg_wr_o), .reg_adr_o(reg_adr_o),
    .reg_dat_o(reg_dat_o), .mux_adr_o(mux_adr_o), .mux_dat_i(mux_dat_i), .busy_o(busy_o),
    .frame_err_o(frame_err_o)
  );
  always #5 clk_i = ~clk_i;
  assign mux_dat_i = mux_adr_o == 3'd5 ? 8'h96 : 8'h40 | {5'b0, mux_adr_o};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk_i) begin
    if (reg_wr_o) begin
      n_wr++;
      check("wr_pending", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) check("wr_adr_dat", 32'({reg_adr_o, reg_dat_o}), 32'(wr_q.pop_front()));
    end
    if (frame_err_o) n_err++;
  end
  task automatic spi_xfer(input logic [31:0] bits, input int n, input int rst_at);
    spi_cs_n_i = 1'b0;
    repeat (6) @(negedge clk_i);
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi_i = bits[i];
      repeat (6) @(negedge clk_i);
      if (miso_q.size() != 0) check("miso", 32'(spi_miso_o), 32'(miso_q.pop_front()));
      if (i == n - 3) check("busy", 32'(busy_o), 32'd1);
      spi_sclk_i = 1'b1;
      repeat (6) @(negedge clk_i);
      if (n - i == rst_at) begin
        rst_n_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
      end
      spi_sclk_i = 1'b0;
    end
    repeat (6) @(negedge clk_i);
    spi_cs_n_i = 1'b1;
    repeat (12) @(negedge clk_i);
  endtask
  initial begin
    int w0, e0;
    logic [7:0] rd_val;
    rd_val = EXP_RD;
    repeat (4) @(negedge clk_i);
    check("rst_miso", 32'(spi_miso_o), 0);
    check("rst_wr", 32'(reg_wr_o), 0);
    check("rst_adr", 32'(reg_adr_o), 0);
    check("rst_dat", 32'(reg_dat_o), 0);
    check("rst_mux", 32'(mux_adr_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_err", 32'(frame_err_o), 0);
    rst_n_i = 1'b1;
    repeat (4) @(negedge clk_i);
    w0 = n_wr; e0 = n_err;
    wr_q.push_back({2'd2, 16'hA5C3});
    spi_xfer({12'b0, 1'b1, 3'b010, 16'hA5C3}, 20, 0);
    check("wr1_cnt", n_wr - w0, 1);
    check("wr1_err", n_err - e0, 0);
    check("wr1_adr", 32'(reg_adr_o), 2);
    check("wr1_dat", 32'(reg_dat_o), 32'hA5C3);
    check("wr1_idle_busy", 32'(busy_o), 0);
    w0 = n_wr; e0 = n_err;
    repeat (4) miso_q.push_back(1'b0);
    for (int b = 7; b >= 0; b--) miso_q.push_back(rd_val[b]);
    repeat (8) miso_q.push_back(1'b0);
    spi_xfer({12'b0, 1'b0, 3'b101, 16'h5A5A}, 20, 0);
    check("rd_mux", 32'(mux_adr_o), 32'(EXP_MUX));
    check("rd_wr", n_wr - w0, 0);
    check("rd_err", n_err - e0, 0);
    check("rd_dat_held", 32'(reg_dat_o), 32'hA5C3);
    check("rd_miso_idle", 32'(spi_miso_o), 0);
    w0 = n_wr; e0 = n_err;
    spi_xfer({21'b0, 1'b1, 3'b001, 7'h7F}, 11, 0);
    check("abort_err", n_err - e0, 1);
    check("abort_wr", n_wr - w0, 0);
    check("abort_adr", 32'(reg_adr_o), 2);
    check("abort_dat", 32'(reg_dat_o), 32'hA5C3);
    check("abort_mux", 32'(mux_adr_o), 32'(EXP_MUX));
    w0 = n_wr; e0 = n_err;
    wr_q.push_back({2'd0, 16'h0001});
    spi_xfer({12'b0, 1'b1, 3'b000, 16'h0001}, 20, 0);
    check("wr2_cnt", n_wr - w0, 1);
    check("wr2_err", n_err - e0, 0);
    check("wr2_dat", 32'(reg_dat_o), 1);
    w0 = n_wr; e0 = n_err;
    spi_xfer({12'b0, 1'b1, 3'b100, 16'h7777}, 20, 0);
    check("badadr_err", n_err - e0, 1);
    check("badadr_wr", n_wr - w0, 0);
    check("badadr_dat", 32'(reg_dat_o), 1);
    w0 = n_wr; e0 = n_err;
    wr_q.push_back({2'd3, 16'h1234});
    spi_xfer({8'b0, 1'b1, 3'b011, 16'h1234, 4'hF}, 24, 0);
    check("long_cnt", n_wr - w0, 1);
    check("long_err", n_err - e0, 0);
    check("long_adr", 32'(reg_adr_o), 3);
    check("long_dat", 32'(reg_dat_o), 32'h1234);
    w0 = n_wr; e0 = n_err;
    spi_xfer({12'b0, 1'b1, 3'b001, 16'hBEEF}, 20, 12);
    check("rstmid_wr", n_wr - w0, 0);
    check("rstmid_err", n_err - e0, 0);
    check("rstmid_adr", 32'(reg_adr_o), 0);
    check("rstmid_dat", 32'(reg_dat_o), 0);
    check("rstmid_mux", 32'(mux_adr_o), 0);
    check("rstmid_busy", 32'(busy_o), 0);
    check("rstmid_miso", 32'(spi_miso_o), 0);
    w0 = n_wr; e0 = n_err;
    wr_q.push_back({2'd1, 16'hBEEF});
    spi_xfer({12'b0, 1'b1, 3'b001, 16'hBEEF}, 20, 0);
    check("wr3_cnt", n_wr - w0, 1);
    check("wr3_err", n_err - e0, 0);
    check("wr3_adr", 32'(reg_adr_o), 1);
    check("wr3_dat", 32'(reg_dat_o), 32'hBEEF);
    check("wr_q_drained", 32'(wr_q.size()), 0);
    check("miso_q_drained", 32'(miso_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/cfg_spi_ctrl.md
# cfg_spi_ctrl

SPI-slave controller that configures and reads back the configuration register block from an external host. It oversamples a mode-0 SPI link in the system clock domain, decodes 20-bit frames, and produces single-cycle register write strobes. It also drives the readback mux select and shifts the selected 8-bit value out on MISO. Sits between the chip-level SPI pads and the configuration register block.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer depth for spi_sclk_i/spi_cs_n_i/spi_mosi_i (≥2)

Ports:
- clk_i  in  1  system clock; all logic on rising edge
- rst_n_i  in  1  reset; synchronous, active-low
- spi_sclk_i  in  1  SPI clock (CPOL=0, CPHA=0), async to clk_i
- spi_cs_n_i  in  1  chip select, active-low, async
- spi_mosi_i  in  1  serial data in, MSB first
- spi_miso_o  out  1  serial data out
- reg_wr_o  out  1  register write strobe, one-cycle pulse
- reg_adr_o  out  2  register address, held between writes
- reg_dat_o  out  16  register write data, held between writes
- mux_adr_o  out  3  readback mux select
- mux_dat_i  in  8  readback mux output (combinational from mux_adr_o)
- busy_o  out  1  high while a frame is in progress (cs_n low, synchronized)
- frame_err_o  out  1  one-cycle pulse on a malformed/aborted frame

## Operation
- Frame, 20 bits MSB first: bit19 = W (1 write, 0 read), bits18:16 = A[2:0], bits15:0 = D.
- Write: A[2] must be 0. On the 20th bit: reg_adr_o<=A[1:0], reg_dat_o<=D, and reg_wr_o pulses. A[2]=1: no strobe, frame_err_o pulses.
- Read: after the 4th bit, mux_adr_o<=A. mux_dat_i is captured into an 8-bit shift register on the following cycle. It is driven on MISO during frame bits 15:8, then 0 for bits 7:0. D bits are ignored, with no strobe.
- FSM: IDLE -> HDR on cs_n fall. HDR -> DATA after 4 rising sclk edges, capturing mux data if read. DATA -> COMMIT after 16 more edges. COMMIT issues the strobe or error, then goes to WAIT_CS. WAIT_CS ignores extra bits and returns to IDLE on cs_n rise.
- cs_n rise in HDR/DATA: frame discarded, frame_err_o pulses, return to IDLE, outputs unchanged.
- cs_n rise coincident with the 20th edge: the frame counts as complete. The edge is processed first.
- Bit counter is 5 bits, cleared on every cs_n fall, saturating at 20.
- MISO updates on synchronized sclk falling edges; 0 whenever cs_n high.
- Reset mid-frame: FSM->IDLE, counter cleared, frame lost. The next frame requires a fresh cs_n fall.

## Timing
- Reset values: spi_miso_o=0, reg_wr_o=0, reg_adr_o=0, reg_dat_o=0, mux_adr_o=0, busy_o=0, frame_err_o=0.
- Input path: SYNC_STAGES flops plus 1 edge-detect flop. Edge is seen SYNC_STAGES+1 cycles after the pad transition.
- Write latency: reg_wr_o high exactly 1 cycle after the detected 20th rising edge.
- Read: mux_adr_o valid 1 cycle after the 4th detected edge; capture 1 cycle later.
- SCLK high/low phases must each be ≥4 clk_i cycles (f_sclk ≤ f_clk/8). This guarantees capture before the first MISO falling edge.
- frame_err_o is 1 cycle after the detected cs_n rise. Back-to-back frames need cs_n high ≥ SYNC_STAGES+2 cycles.

## Configuration
- CFG_SPI_READBACK_EN defined: read frames are supported as above.
- Undefined: read path removed. mux_adr_o tied 0, spi_miso_o tied 0, no capture register. Read frames are consumed silently with no error and no strobe.

## Structure
- Package cfg_spi_pkg:
  - FRAME_LEN=20, HDR_LEN=4, RD_LEN=8
  - state enum (IDLE, HDR, DATA, COMMIT, WAIT_CS)
  - OP_WR=1'b1, OP_RD=1'b0
- Sub-module cfg_spi_sync: SYNC_STAGES-deep synchronizer with rise/fall detect. Three instances: sclk, cs_n, mosi (mosi uses level only).

## Test plan
- Write frame W=1, A=3'b010, D=16'hA5C3 -> single reg_wr_o pulse; reg_adr_o=2, reg_dat_o=16'hA5C3, held afterwards.
- Read frame A=3'b101, mux_dat_i=8'h96 when sel=5 -> mux_adr_o=5; MISO bits 15:8 = 1,0,0,1,0,1,1,0, then eight 0s; no strobe.
- Abort after 11 bits (cs_n rise) -> frame_err_o one pulse, no strobe, outputs unchanged. The next full write of D=16'h0001 to A=0 succeeds.
- Write with A=3'b100 -> frame_err_o pulse, no reg_wr_o. A 24-bit valid write frame -> exactly one strobe and the last 4 bits are ignored.
- rst_n_i low for 1 cycle at bit 12 of a write -> no strobe; all outputs return to reset values. A following clean frame commits normally.
- CFG_SPI_READBACK_EN undefined, read frame A=5 -> mux_adr_o=0, MISO=0 throughout, no error, no strobe.
